// File: rtl/debugger_rx_ctrl.sv
// debugger_rx_ctrl
//   Command/control stage of the MIPS debug unit, upstream of the debug UART
//   transmitter. It decodes single-byte commands, gates the CPU clock enable
//   for continuous run or single step, snapshots the CPU debug frame and then
//   hands the frozen snapshot to the transmitter.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   rx_done_tick    one-cycle strobe, rx_data valid
//   rx_data         received command byte
//   cpu_halted      CPU reached end of program (level)
//   frame_in        live CPU debug frame
//   data_sent       transmitter status: 1 = idle/finished, 0 = frame in flight
//   cpu_enable      CPU clock enable (RUN or STEP)
//   send_signal     one-cycle start request to the transmitter (SEND)
//   send_data       frozen snapshot presented to the transmitter
//   state_out       current state encoding
//   cycle_count     number of cycles cpu_enable has been high (wraps)
//   cmd_error       one-cycle pulse: received byte rejected
//   tx_timeout      one-cycle pulse: transmitter never started
//
// Transmitter handshake: send_signal is a one-cycle request; the transmitter
// accepts it by pulling data_sent low and completes by raising it again.
// send_data is held constant from the SNAP edge until data_sent returns high.
module debugger_rx_ctrl #(
  parameter int         FRAME_BITS  = 1720,
  parameter logic [7:0] CMD_CONT    = 8'h63,
  parameter logic [7:0] CMD_STEP    = 8'h73,
  parameter logic [7:0] CMD_READ    = 8'h72,
  parameter logic [7:0] CMD_HALT    = 8'h68,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            rx_data,
  input  logic                  cpu_halted,
  input  logic [FRAME_BITS-1:0] frame_in,
  input  logic                  data_sent,
  output logic                  cpu_enable,
  output logic                  send_signal,
  output logic [FRAME_BITS-1:0] send_data,
  output logic [2:0]            state_out,
  output logic [15:0]           cycle_count,
  output logic                  cmd_error,
  output logic                  tx_timeout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RUN        = 3'd1,
    S_STEP       = 3'd2,
    S_SNAP       = 3'd3,
    S_SEND       = 3'd4,
    S_WAIT_START = 3'd5,
    S_WAIT_DONE  = 3'd6
  } state_t;

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state, state_next;
  logic [TW-1:0] tmo_cnt, tmo_cnt_next;
  logic          err_next, tmo_next;

  always_comb begin
    state_next   = state;
    tmo_cnt_next = tmo_cnt;
    err_next     = 1'b0;
    tmo_next     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_done_tick) begin
          case (rx_data)
            CMD_CONT: state_next = S_RUN;
            CMD_STEP: state_next = S_STEP;
            CMD_READ: state_next = S_SNAP;
            CMD_HALT: state_next = S_IDLE;
            default:  err_next   = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        // Halt request and program end may coincide; either one exits once.
        if (cpu_halted || (rx_done_tick && rx_data == CMD_HALT))
          state_next = S_SNAP;
        if (rx_done_tick && rx_data != CMD_HALT)
          err_next = 1'b1;
      end
      S_STEP:  state_next = S_SNAP;
      S_SNAP:  state_next = S_SEND;
      S_SEND: begin
        tmo_cnt_next = '0;
        state_next   = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!data_sent) begin
          state_next = S_WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_IDLE;
          tmo_next   = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (data_sent) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Commands are not queued while a step or transfer is in progress.
    if (rx_done_tick && state != S_IDLE && state != S_RUN)
      err_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      cmd_error   <= 1'b0;
      tx_timeout  <= 1'b0;
      cycle_count <= '0;
      send_data   <= '0;
    end else begin
      state      <= state_next;
      tmo_cnt    <= tmo_cnt_next;
      cmd_error  <= err_next;
      tx_timeout <= tmo_next;
      if (cpu_enable) cycle_count <= cycle_count + 16'd1;
      // Frame is captured one cycle after the last enabled CPU cycle.
      if (state == S_SNAP) send_data <= frame_in;
    end
  end

  assign cpu_enable  = (state == S_RUN) || (state == S_STEP);
  assign send_signal = (state == S_SEND);
  assign state_out   = state;

endmodule

// File: tb/tb_debugger_rx_ctrl.sv
// Directed testbench for debugger_rx_ctrl. Inputs are driven and outputs
// sampled 1 ns after the rising edge; pulse monitors count at the edge.
module tb_debugger_rx_ctrl;

  localparam int FB = 1720;
  localparam logic [7:0] C_CONT = 8'h63, C_STEP = 8'h73, C_READ = 8'h72, C_HALT = 8'h68;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_RUN = 3'd1, ST_STEP = 3'd2, ST_SNAP = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4, ST_WSTART = 3'd5, ST_WDONE = 3'd6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_done_tick = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          cpu_halted = 1'b0;
  logic [FB-1:0] frame_in = '0;
  logic          data_sent = 1'b1;
  logic          cpu_enable, send_signal, cmd_error, tx_timeout;
  logic [FB-1:0] send_data;
  logic [2:0]    state_out;
  logic [15:0]   cycle_count;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0, sp_cnt = 0, err_cnt = 0, to_cnt = 0;
  int en0, sp0, err0, to0;
  logic [FB-1:0] f1, f2, f3, f4, f5;

  debugger_rx_ctrl dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .cpu_halted(cpu_halted), .frame_in(frame_in), .data_sent(data_sent),
    .cpu_enable(cpu_enable), .send_signal(send_signal), .send_data(send_data),
    .state_out(state_out), .cycle_count(cycle_count), .cmd_error(cmd_error),
    .tx_timeout(tx_timeout)
  );

  // clock
  always #5 clk = ~clk;

  // pulse / enable monitors
  always @(posedge clk) begin
    if (!reset) begin
      if (cpu_enable)  en_cnt  <= en_cnt + 1;
      if (send_signal) sp_cnt  <= sp_cnt + 1;
      if (cmd_error)   err_cnt <= err_cnt + 1;
      if (tx_timeout)  to_cnt  <= to_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FB-1:0] make_frame(input logic [7:0] seed);
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < FB / 8; i++) f[i*8 +: 8] = seed + 8'(i * 3);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input string tag);
    for (int i = 0; i < 200 && state_out != target; i++) tick();
    chk(tag, 64'(state_out), 64'(target));
  endtask

  task automatic snapshot();
    en0 = en_cnt; sp0 = sp_cnt; err0 = err_cnt; to0 = to_cnt;
  endtask

  // Drives the transmitter side: data_sent falls two cycles after the request,
  // stays low 20+ cycles; frame_in is scrambled while the frame is in flight.
  task automatic do_transfer(input logic [FB-1:0] exp_frame, input bit inject, input string tag);
    wait_state(ST_SEND, {tag, "_send"});
    chk({tag, "_send_signal"}, 64'(send_signal), 64'd1);
    tick();
    chk({tag, "_wstart"}, 64'(state_out), 64'(ST_WSTART));
    tick();
    data_sent = 1'b0;
    tick();
    chk({tag, "_wdone"}, 64'(state_out), 64'(ST_WDONE));
    frame_in = ~exp_frame;
    if (inject) begin
      send_byte(C_STEP);
      chk({tag, "_inj_err"}, 64'(cmd_error), 64'd1);
      chk({tag, "_inj_state"}, 64'(state_out), 64'(ST_WDONE));
    end
    repeat (20) tick();
    chk({tag, "_frame_held"}, 64'(send_data === exp_frame), 64'd1);
    data_sent = 1'b1;
    tick();
    chk({tag, "_idle"}, 64'(state_out), 64'(ST_IDLE));
    chk({tag, "_frame_kept"}, 64'(send_data === exp_frame), 64'd1);
    chk({tag, "_send_once"}, 64'(sp_cnt - sp0), 64'd1);
  endtask

  initial begin
    f1 = make_frame(8'h11); f2 = make_frame(8'h5a); f3 = make_frame(8'hc3);
    f4 = make_frame(8'h27); f5 = make_frame(8'h90);

    // reset values
    tick(); tick();
    chk("rst_state", 64'(state_out), 64'(ST_IDLE));
    chk("rst_en", 64'(cpu_enable), 64'd0);
    chk("rst_send", 64'(send_signal), 64'd0);
    chk("rst_data", 64'(send_data === '0), 64'd1);
    chk("rst_count", 64'(cycle_count), 64'd0);
    chk("rst_err", 64'(cmd_error), 64'd0);
    chk("rst_tmo", 64'(tx_timeout), 64'd0);
    reset = 1'b0;
    tick();

    // single step
    snapshot();
    frame_in = f1;
    send_byte(C_STEP);
    chk("step_state", 64'(state_out), 64'(ST_STEP));
    chk("step_en", 64'(cpu_enable), 64'd1);
    tick();
    chk("step_snap", 64'(state_out), 64'(ST_SNAP));
    chk("step_en_off", 64'(cpu_enable), 64'd0);
    do_transfer(f1, 1'b0, "step");
    chk("step_count", 64'(cycle_count), 64'd1);
    chk("step_en_cycles", 64'(en_cnt - en0), 64'd1);
    chk("step_no_err", 64'(err_cnt - err0), 64'd0);

    // continuous run ending on cpu_halted: 51 enabled cycles
    snapshot();
    frame_in = f2;
    send_byte(C_CONT);
    chk("run_state", 64'(state_out), 64'(ST_RUN));
    repeat (50) tick();
    chk("run_still", 64'(state_out), 64'(ST_RUN));
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    chk("run_snap", 64'(state_out), 64'(ST_SNAP));
    do_transfer(f2, 1'b0, "run");
    chk("run_count", 64'(cycle_count), 64'd52);
    chk("run_en_cycles", 64'(en_cnt - en0), 64'd51);

    // continuous run stopped by 'h' after 10 cycles, frame changes in flight
    snapshot();
    frame_in = f3;
    send_byte(C_CONT);
    repeat (9) tick();
    send_byte(C_HALT);
    chk("halt_snap", 64'(state_out), 64'(ST_SNAP));
    do_transfer(f3, 1'b0, "halt");
    chk("halt_count", 64'(cycle_count), 64'd62);
    chk("halt_no_err", 64'(err_cnt - err0), 64'd0);

    // read only
    snapshot();
    frame_in = f4;
    send_byte(C_READ);
    chk("read_snap", 64'(state_out), 64'(ST_SNAP));
    do_transfer(f4, 1'b0, "read");
    chk("read_count", 64'(cycle_count), 64'd62);
    chk("read_en_cycles", 64'(en_cnt - en0), 64'd0);

    // rejected bytes: unknown in IDLE, 's' during WAIT_DONE
    snapshot();
    send_byte(8'h41);
    chk("bad_err", 64'(cmd_error), 64'd1);
    chk("bad_state", 64'(state_out), 64'(ST_IDLE));
    tick();
    chk("bad_err_clr", 64'(cmd_error), 64'd0);
    frame_in = f5;
    send_byte(C_READ);
    do_transfer(f5, 1'b1, "busy");
    chk("busy_err_pulses", 64'(err_cnt - err0), 64'd2);
    chk("busy_en_cycles", 64'(en_cnt - en0), 64'd0);
    chk("busy_count", 64'(cycle_count), 64'd62);

    // transmitter never starts
    snapshot();
    send_byte(C_READ);
    tick();
    chk("tmo_send", 64'(state_out), 64'(ST_SEND));
    tick();
    chk("tmo_wstart", 64'(state_out), 64'(ST_WSTART));
    repeat (1023) tick();
    chk("tmo_still_wait", 64'(state_out), 64'(ST_WSTART));
    chk("tmo_not_yet", 64'(tx_timeout), 64'd0);
    tick();
    chk("tmo_idle", 64'(state_out), 64'(ST_IDLE));
    chk("tmo_pulse", 64'(tx_timeout), 64'd1);
    tick();
    chk("tmo_pulse_clr", 64'(tx_timeout), 64'd0);
    chk("tmo_pulses", 64'(to_cnt - to0), 64'd1);

    // reset during WAIT_DONE
    frame_in = f2;
    send_byte(C_READ);
    wait_state(ST_SEND, "mrst_send");
    tick(); tick();
    data_sent = 1'b0;
    tick();
    chk("mrst_wdone", 64'(state_out), 64'(ST_WDONE));
    reset = 1'b1;
    #1;
    chk("mrst_state", 64'(state_out), 64'(ST_IDLE));
    chk("mrst_data", 64'(send_data === '0), 64'd1);
    chk("mrst_count", 64'(cycle_count), 64'd0);
    chk("mrst_en", 64'(cpu_enable), 64'd0);
    chk("mrst_send", 64'(send_signal), 64'd0);
    data_sent = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // 'h' in IDLE is harmless; cpu_halted held high makes 'c' a one-cycle run
    snapshot();
    cpu_halted = 1'b1;
    send_byte(C_HALT);
    chk("idle_halt_state", 64'(state_out), 64'(ST_IDLE));
    chk("idle_halt_err", 64'(cmd_error), 64'd0);
    repeat (3) tick();
    chk("idle_halted_ign", 64'(state_out), 64'(ST_IDLE));
    frame_in = f3;
    send_byte(C_CONT);
    chk("hc_run", 64'(state_out), 64'(ST_RUN));
    tick();
    cpu_halted = 1'b0;
    chk("hc_snap", 64'(state_out), 64'(ST_SNAP));
    do_transfer(f3, 1'b0, "hc");
    chk("hc_count", 64'(cycle_count), 64'd1);
    chk("hc_no_err", 64'(err_cnt - err0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
